// File: rtl/ram_wr_ctrl.sv
// Write-side controller for the single-port RAM demo: seeded ramp fill on a key press,
// then a slow read-address walk for the display, with pause/refill on later key presses.
module ram_wr_ctrl #(
  parameter logic [23:0] CNT_MAX = 24'd4_999_999,
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              key_flag,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fill_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   seed, seed_nx;
  logic [23:0]         cnt, cnt_nx;
  logic                tick, tick_nx;

  logic                wr_en_nx, rd_en_nx, fill_done_nx, busy_nx;
  logic [ADDR_W-1:0]   wr_addr_nx, rd_addr_nx, wr_addr_inc;
  logic [DATA_W-1:0]   wr_data_nx, seed_inc;

  assign wr_addr_inc = wr_addr + ADDR_ONE;
  assign seed_inc    = seed + DATA_ONE;
  assign state_dbg   = state;

  // Every output is computed one cycle early here and registered below, so the
  // RAM sees glitch-free strobes and wr_en/rd_en can never overlap.
  always_comb begin
    state_nx     = state;
    seed_nx      = seed;
    cnt_nx       = cnt;
    tick_nx      = 1'b0;
    wr_en_nx     = 1'b0;
    wr_addr_nx   = '0;
    wr_data_nx   = '0;
    rd_en_nx     = 1'b0;
    rd_addr_nx   = rd_addr;
    fill_done_nx = 1'b0;

    case (state)
      IDLE: begin
        if (key_flag) begin
          state_nx   = WRITE;
          wr_en_nx   = 1'b1;
          wr_data_nx = seed;
        end
      end

      WRITE: begin
        if (wr_addr == LAST_ADDR) begin
          state_nx     = READ;
          fill_done_nx = 1'b1;
          rd_en_nx     = 1'b1;
          rd_addr_nx   = '0;
          cnt_nx       = '0;
        end else begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = wr_addr_inc;
          wr_data_nx = DATA_W'(wr_addr_inc) + seed;
        end
      end

      READ: begin
        rd_en_nx = 1'b1;
        // A key press drops any pending tick so the address freezes where it is.
        if (key_flag) begin
          state_nx = PAUSE;
        end else begin
          cnt_nx  = (cnt == CNT_MAX) ? 24'd0 : cnt + 24'd1;
          tick_nx = (cnt == CNT_MAX);
          if (tick) begin
            rd_addr_nx = rd_addr + ADDR_ONE;
          end
        end
      end

      PAUSE: begin
        if (key_flag) begin
          state_nx   = WRITE;
          seed_nx    = seed_inc;
          wr_en_nx   = 1'b1;
          wr_data_nx = seed_inc;
        end else begin
          rd_en_nx = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == WRITE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seed      <= '0;
      cnt       <= '0;
      tick      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      fill_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      seed      <= seed_nx;
      cnt       <= cnt_nx;
      tick      <= tick_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      rd_en     <= rd_en_nx;
      rd_addr   <= rd_addr_nx;
      fill_done <= fill_done_nx;
      busy      <= busy_nx;
    end
  end

endmodule
